kbd_nibble_tx: RTL and testbench
================================

Name: kbd_nibble_tx

Overview:
- Transmit end of the 4-bit keyboard nibble link that the PS/2 receive driver consumes on kbd_enb_hi / kbd_enb_lo / kbd_data.
- Accepts bytes on a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as a high-nibble strobe followed by a low-nibble strobe, with programmable setup, strobe, hold and inter-byte gap timing.
- Used as a keyboard emulator and as a loopback source for the keyboard path.

Parameters:
- SETUP_CYC, 4: cycles kbd_data is stable before a strobe rises; also the hold time after it falls; must be ≥1.
- STROBE_CYC, 8: cycles each strobe is held high; must be ≥1.
- GAP_CYC, 16: idle cycles after the low-nibble hold, before the next byte; 0 skips the gap.
- FIFO_AW, 3: FIFO address width; depth = 2^FIFO_AW.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- tx_data, input, 8: byte to send.
- tx_valid, input, 1: tx_data valid.
- tx_ready, output, 1: FIFO can accept a byte; combinational !full; forced 0 while rst=1.
- kbd_enb_hi, output, 1: registered high-nibble strobe.
- kbd_enb_lo, output, 1: registered low-nibble strobe.
- kbd_data, output, 4: registered nibble.
- busy, output, 1: FSM not in IDLE, or FIFO non-empty.
- fifo_count, output, FIFO_AW+1: number of bytes held in the FIFO.

Behaviour:
- Reset, synchronous, active-high:
  - FIFO is flushed and fifo_count = 0.
  - FSM goes to IDLE; all counters clear.
  - kbd_enb_hi = kbd_enb_lo = 0, kbd_data = 0, busy = 0.
  - A reset in the middle of a byte drops any strobe on the same edge and discards both the byte in flight and the FIFO contents.
- Handshake:
  - A byte is pushed on any edge where tx_valid && tx_ready.
  - When full, tx_ready = 0 and tx_valid is ignored; no overwrite occurs.
  - A push and a pop on the same edge leave fifo_count unchanged.
- FSM states: IDLE, HI_SETUP, HI_STROBE, HI_HOLD, LO_SETUP, LO_STROBE, LO_HOLD, GAP. A 16-bit down-counter controls the dwell in each timed state.
- Per-state behaviour:
  - IDLE: if FIFO non-empty, pop into the shift register, set kbd_data = byte[7:4], go to HI_SETUP. Otherwise kbd_data holds its last value.
  - HI_SETUP: stay SETUP_CYC cycles with strobes low, then go to HI_STROBE.
  - HI_STROBE: kbd_enb_hi = 1 for exactly STROBE_CYC cycles.
  - HI_HOLD: strobe low for SETUP_CYC cycles with data held. On exit, kbd_data = byte[3:0].
  - LO_SETUP, LO_STROBE, LO_HOLD: same as the HI states, using kbd_enb_lo.
  - GAP: GAP_CYC cycles, kbd_data held; then return to IDLE.
- Latency:
  - A byte accepted into an empty, idle block at edge N gets kbd_data = high nibble from edge N+2.
  - kbd_enb_hi rises at edge N+2+SETUP_CYC.
- Per-byte timing:
  - One byte occupies 1 + 2·(2·SETUP_CYC + STROBE_CYC) + GAP_CYC cycles from leaving IDLE to the next pop.
  - With default parameters this is 49 cycles.
- Invariants:
  - kbd_enb_hi and kbd_enb_lo are never both high.
  - kbd_data never changes while a strobe is high.

Optional Feature:
- Macro: KBD_TX_ASCII_FILTER_EN.
- When defined:
  - A byte with bit 7 set is still popped, but is not transmitted. The FSM stays in IDLE and may pop the next byte on the following cycle.
  - Added output port drop_pulse (1 bit) pulses high for one cycle per dropped byte.
  - busy covers the drop cycle.
- When undefined:
  - All 8-bit values are transmitted unchanged.
  - The drop_pulse port does not exist.

Test Plan:
- Reset, then push 0xA5 at edge N:
  - kbd_data = 4'hA from N+2.
  - kbd_enb_hi high for edges N+6 .. N+13.
  - kbd_data = 4'h5 from N+18.
  - kbd_enb_lo high for edges N+22 .. N+29.
  - busy falls after the 16-cycle gap.
- Push 0x31, 0x32, 0x33 back-to-back: the rising edges of kbd_enb_hi are spaced exactly 49 cycles apart, and the low nibbles seen on kbd_data are 1, 2, 3.
- With the FSM stalled mid-byte, push 8 bytes:
  - fifo_count reaches 8 and tx_ready = 0.
  - A 9th tx_valid is not accepted.
  - All 8 bytes are emitted in order.
- Assert rst while kbd_enb_hi = 1:
  - The strobe is 0 on the next edge.
  - fifo_count = 0.
  - No further strobes appear after rst deasserts.
- Build with GAP_CYC=0, SETUP_CYC=1, STROBE_CYC=1: each byte takes 7 cycles, and the strobes never overlap.
- With KBD_TX_ASCII_FILTER_EN defined, push 0x80 then 0x41:
  - One drop_pulse occurs and 0x80 produces no strobe.
  - 0x41 is emitted with kbd_data 4 then 1.

Source files
------------

// File: rtl/kbd_nibble_tx_if.sv
// Byte-stream handshake into the keyboard nibble transmitter.
//   tx_data  : byte offered by the producer
//   tx_valid : tx_data is valid this cycle
//   tx_ready : transmitter FIFO can take a byte this cycle
// Modports: master = byte producer, slave = kbd_nibble_tx.
interface kbd_nibble_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/kbd_nibble_tx.sv
// Transmit end of the 4-bit keyboard nibble link. Bytes arrive on a valid/ready handshake,
// are buffered in a 2^FIFO_AW entry FIFO and sent as a high-nibble strobe followed by a
// low-nibble strobe with programmable setup/strobe/hold/gap timing.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   tx         : slave side of kbd_nibble_tx_if (tx_data, tx_valid, tx_ready)
//   kbd_enb_hi : registered high-nibble strobe
//   kbd_enb_lo : registered low-nibble strobe
//   kbd_data   : registered nibble
//   busy       : FSM not idle or FIFO not empty
//   fifo_count : bytes held in the FIFO
//   drop_pulse : one-cycle pulse per discarded byte (KBD_TX_ASCII_FILTER_EN only)
//
// Build option: define KBD_TX_ASCII_FILTER_EN to pop and discard bytes with bit 7 set
// instead of transmitting them.
module kbd_nibble_tx #(
  parameter int unsigned SETUP_CYC  = 4,
  parameter int unsigned STROBE_CYC = 8,
  parameter int unsigned GAP_CYC    = 16,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  kbd_nibble_tx_if.slave       tx,
  output logic                 kbd_enb_hi,
  output logic                 kbd_enb_lo,
  output logic [3:0]           kbd_data,
  output logic                 busy,
  output logic [FIFO_AW:0]     fifo_count
`ifdef KBD_TX_ASCII_FILTER_EN
  ,
  output logic                 drop_pulse
`endif
);

  typedef enum logic [2:0] {
    StIdle, StHiSetup, StHiStrobe, StHiHold, StLoSetup, StLoStrobe, StLoHold, StGap
  } state_e;

  localparam int unsigned     Depth    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);
  // Dwell counters count down to zero, so they load duration - 1.
  localparam logic [15:0]     SetupLd  = 16'(SETUP_CYC - 1);
  localparam logic [15:0]     StrobeLd = 16'(STROBE_CYC - 1);
  localparam logic [15:0]     GapLd    = 16'(GAP_CYC - 1);

  // ---------------------------------------------------------------- FIFO
  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               avail_q;
  logic               full, push, pop;
  logic [7:0]         head;

  assign full        = (count_q == DepthCnt);
  assign tx.tx_ready = ~full & ~rst;
  assign push        = tx.tx_valid & tx.tx_ready;
  assign head        = mem_q[rd_ptr_q];
  assign fifo_count  = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx.tx_data;
  end

  // The FSM sees occupancy through avail_q, one cycle behind the write, so a byte pushed
  // into an idle block is popped on the second edge after it is accepted. The pending pop
  // is subtracted so a back-to-back pop never reads an empty FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      avail_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      avail_q <= (count_q > (FIFO_AW + 1)'(pop));
    end
  end

  // ---------------------------------------------------------------- FSM
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  data_d;
  logic        enb_hi_d, enb_lo_d;
  logic        drop_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = kbd_data;
    pop     = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (avail_q) begin
          pop = 1'b1;
`ifdef KBD_TX_ASCII_FILTER_EN
          drop_d = head[7];
`endif
          if (!drop_d) begin
            sh_d    = head;
            data_d  = head[7:4];
            cnt_d   = SetupLd;
            state_d = StHiSetup;
          end
        end
      end
      StHiSetup, StLoSetup: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = StrobeLd;
          state_d = (state_q == StHiSetup) ? StHiStrobe : StLoStrobe;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StHiStrobe, StLoStrobe: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = SetupLd;
          state_d = (state_q == StHiStrobe) ? StHiHold : StLoHold;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StHiHold: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = SetupLd;
          data_d  = sh_q[3:0];
          state_d = StLoSetup;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StLoHold: begin
        if (cnt_q == 16'd0) begin
          if (GAP_CYC == 0) begin
            cnt_d   = 16'd0;
            state_d = StIdle;
          end else begin
            cnt_d   = GapLd;
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StGap: begin
        if (cnt_q == 16'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = StIdle;
      end
    endcase
    enb_hi_d = (state_d == StHiStrobe);
    enb_lo_d = (state_d == StLoStrobe);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 16'd0;
      sh_q       <= 8'd0;
      kbd_data   <= 4'd0;
      kbd_enb_hi <= 1'b0;
      kbd_enb_lo <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      kbd_data   <= data_d;
      kbd_enb_hi <= enb_hi_d;
      kbd_enb_lo <= enb_lo_d;
    end
  end

`ifdef KBD_TX_ASCII_FILTER_EN
  always_ff @(posedge clk) begin
    if (rst) drop_pulse <= 1'b0;
    else     drop_pulse <= drop_d;
  end

  assign busy = (state_q != StIdle) | (count_q != '0) | drop_pulse;
`else
  assign busy = (state_q != StIdle) | (count_q != '0);
`endif

endmodule

// File: tb/tb_kbd_nibble_tx.sv
module tb_kbd_nibble_tx;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kbd_nibble_tx_if ifa ();
  kbd_nibble_tx_if ifb ();

  logic       hi_a, lo_a, busy_a, hi_b, lo_b, busy_b;
  logic [3:0] data_a, data_b, cnt_a, cnt_b;
`ifdef KBD_TX_ASCII_FILTER_EN
  logic       drop_a, drop_b;
`endif

  kbd_nibble_tx u_a (
    .clk(clk), .rst(rst), .tx(ifa), .kbd_enb_hi(hi_a), .kbd_enb_lo(lo_a), .kbd_data(data_a),
    .busy(busy_a), .fifo_count(cnt_a)
`ifdef KBD_TX_ASCII_FILTER_EN
    , .drop_pulse(drop_a)
`endif
  );

  kbd_nibble_tx #(.SETUP_CYC(1), .STROBE_CYC(1), .GAP_CYC(0), .FIFO_AW(3)) u_b (
    .clk(clk), .rst(rst), .tx(ifb), .kbd_enb_hi(hi_b), .kbd_enb_lo(lo_b), .kbd_data(data_b),
    .busy(busy_b), .fifo_count(cnt_b)
`ifdef KBD_TX_ASCII_FILTER_EN
    , .drop_pulse(drop_b)
`endif
  );

  // Scoreboards: expected bytes in send order, plus logs of strobe events.
  logic [7:0] exp_a[$], exp_b[$];
  int         hi_rise_a[$], hi_rise_b[$];
  logic [3:0] lo_nib_a[$];
  int         drops_a = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic spurious(input string name);
    total++;
    bad++;
    $display("FAIL %s: got a strobe expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor for the default-parameter instance.
  initial begin
    logic ph, pl;
    logic [3:0] held;
    ph = 1'b0; pl = 1'b0; held = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hi_a && !ph) begin
          hi_rise_a.push_back(cyc);
          check("a_overlap_hi", 32'(lo_a), 32'd0);
          if (exp_a.size() == 0) spurious("a_hi_strobe");
          else check("a_hi_nibble", 32'(data_a), 32'(exp_a[0] >> 4));
          held = data_a;
        end else if (hi_a) begin
          check("a_hi_stable", 32'(data_a), 32'(held));
        end
        if (lo_a && !pl) begin
          check("a_overlap_lo", 32'(hi_a), 32'd0);
          if (exp_a.size() == 0) spurious("a_lo_strobe");
          else begin
            check("a_lo_nibble", 32'(data_a), 32'(exp_a[0] & 8'h0f));
            void'(exp_a.pop_front());
          end
          lo_nib_a.push_back(data_a);
          held = data_a;
        end else if (lo_a) begin
          check("a_lo_stable", 32'(data_a), 32'(held));
        end
`ifdef KBD_TX_ASCII_FILTER_EN
        if (drop_a) drops_a++;
`endif
      end
      ph = hi_a;
      pl = lo_a;
    end
  end

  // Monitor for the minimum-timing instance.
  initial begin
    logic ph, pl;
    ph = 1'b0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hi_b && !ph) begin
          hi_rise_b.push_back(cyc);
          check("b_overlap_hi", 32'(lo_b), 32'd0);
          if (exp_b.size() == 0) spurious("b_hi_strobe");
          else check("b_hi_nibble", 32'(data_b), 32'(exp_b[0] >> 4));
        end
        if (lo_b && !pl) begin
          check("b_overlap_lo", 32'(hi_b), 32'd0);
          if (exp_b.size() == 0) spurious("b_lo_strobe");
          else begin
            check("b_lo_nibble", 32'(data_b), 32'(exp_b[0] & 8'h0f));
            void'(exp_b.pop_front());
          end
        end
      end
      ph = hi_b;
      pl = lo_b;
    end
  end

  // Offers one byte; returns the edge number at which it was accepted.
  task automatic push(input int which, input logic [7:0] b, output int n);
    int   guard;
    logic keep;
    guard = 0;
    keep  = 1'b1;
`ifdef KBD_TX_ASCII_FILTER_EN
    keep = ~b[7];
`endif
    @(negedge clk);
    while (((which == 0) ? !ifa.tx_ready : !ifb.tx_ready) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready_timeout", 32'(guard >= 3000), 32'd0);
    if (which == 0) begin ifa.tx_data = b; ifa.tx_valid = 1'b1; end
    else begin ifb.tx_data = b; ifb.tx_valid = 1'b1; end
    @(posedge clk);
    #1;
    n = cyc;
    if (which == 0) begin
      ifa.tx_valid = 1'b0;
      if (keep) exp_a.push_back(b);
    end else begin
      ifb.tx_valid = 1'b0;
      if (keep) exp_b.push_back(b);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle(input int which, input int budget, input string name);
    int g;
    g = 0;
    while (g < budget && ((which == 0) ? (busy_a || exp_a.size() != 0)
                                       : (busy_b || exp_b.size() != 0))) begin
      @(negedge clk);
      g++;
    end
    check({name, "_busy"}, 32'((which == 0) ? busy_a : busy_b), 32'd0);
    check({name, "_pending"}, 32'((which == 0) ? exp_a.size() : exp_b.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish by 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    int n, n0, r0, l0, g;
    rst = 1'b1;
    ifa.tx_valid = 1'b0; ifa.tx_data = 8'h00;
    ifb.tx_valid = 1'b0; ifb.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_enb_hi", 32'(hi_a), 32'd0);
    check("rst_enb_lo", 32'(lo_a), 32'd0);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_count", 32'(cnt_a), 32'd0);
    check("rst_ready", 32'(ifa.tx_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ifa.tx_ready), 32'd1);

    // Single byte 0xA5: exact latency and strobe windows.
    push(0, 8'hA5, n);
    wait_until(n + 2);  check("a5_hi_data", 32'(data_a), 32'hA);
    wait_until(n + 5);  check("a5_hi_pre", 32'(hi_a), 32'd0);
    wait_until(n + 6);  check("a5_hi_first", 32'(hi_a), 32'd1);
    wait_until(n + 13); check("a5_hi_last", 32'(hi_a), 32'd1);
    wait_until(n + 14); check("a5_hi_post", 32'(hi_a), 32'd0);
    wait_until(n + 17); check("a5_data_held", 32'(data_a), 32'hA);
    wait_until(n + 18); check("a5_lo_data", 32'(data_a), 32'h5);
    wait_until(n + 21); check("a5_lo_pre", 32'(lo_a), 32'd0);
    wait_until(n + 22); check("a5_lo_first", 32'(lo_a), 32'd1);
    wait_until(n + 29); check("a5_lo_last", 32'(lo_a), 32'd1);
    wait_until(n + 30); check("a5_lo_post", 32'(lo_a), 32'd0);
    wait_until(n + 49); check("a5_busy_gap", 32'(busy_a), 32'd1);
    wait_until(n + 50); check("a5_busy_end", 32'(busy_a), 32'd0);

    // Back-to-back bytes: 49-cycle byte period.
    hi_rise_a.delete();
    lo_nib_a.delete();
    push(0, 8'h31, n); push(0, 8'h32, n); push(0, 8'h33, n);
    wait_idle(0, 400, "b2b");
    check("b2b_rises", 32'(hi_rise_a.size()), 32'd3);
    if (hi_rise_a.size() == 3 && lo_nib_a.size() == 3) begin
      check("b2b_space1", 32'(hi_rise_a[1] - hi_rise_a[0]), 32'd49);
      check("b2b_space2", 32'(hi_rise_a[2] - hi_rise_a[1]), 32'd49);
      check("b2b_lo0", 32'(lo_nib_a[0]), 32'h1);
      check("b2b_lo1", 32'(lo_nib_a[1]), 32'h2);
      check("b2b_lo2", 32'(lo_nib_a[2]), 32'h3);
    end

    // Fill the FIFO while a byte is in flight.
    push(0, 8'h10, n0);
    repeat (10) @(negedge clk);
    check("fill_in_flight", 32'(busy_a), 32'd1);
    for (int i = 0; i < 8; i++) push(0, 8'h21 + 8'(i), n);
    check("fill_count", 32'(cnt_a), 32'd8);
    check("fill_ready", 32'(ifa.tx_ready), 32'd0);
    @(negedge clk);
    ifa.tx_data = 8'hEE;
    ifa.tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("full_no_push", 32'(cnt_a), 32'd8);
    end
    ifa.tx_valid = 1'b0;
    wait_idle(0, 700, "fill_drain");

`ifdef KBD_TX_ASCII_FILTER_EN
    // Bit-7 byte is discarded, next byte still sent.
    drops_a = 0;
    lo_nib_a.delete();
    push(0, 8'h80, n); push(0, 8'h41, n);
    wait_idle(0, 200, "filter");
    check("filter_drops", 32'(drops_a), 32'd1);
    check("filter_sent", 32'(lo_nib_a.size()), 32'd1);
`endif

    // Minimum timing: 7-cycle byte period.
    hi_rise_b.delete();
    push(1, 8'h5A, n0); push(1, 8'hC3, n); push(1, 8'h7E, n);
    wait_idle(1, 100, "fast");
    check("fast_rises", 32'(hi_rise_b.size()), 32'd3);
    if (hi_rise_b.size() == 3) begin
      check("fast_latency", 32'(hi_rise_b[0] - n0), 32'd3);
      check("fast_space1", 32'(hi_rise_b[1] - hi_rise_b[0]), 32'd7);
      check("fast_space2", 32'(hi_rise_b[2] - hi_rise_b[1]), 32'd7);
    end

    // Reset in the middle of a high strobe.
    push(0, 8'h11, n); push(0, 8'h22, n); push(0, 8'h33, n);
    g = 0;
    while (!hi_a && g < 100) begin @(negedge clk); g++; end
    check("mid_rst_strobe_seen", 32'(hi_a), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_hi", 32'(hi_a), 32'd0);
    check("mid_rst_count", 32'(cnt_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    exp_a.delete();
    exp_b.delete();
    @(negedge clk);
    rst = 1'b0;
    r0 = hi_rise_a.size();
    l0 = lo_nib_a.size();
    repeat (150) @(negedge clk);
    check("post_rst_no_hi", 32'(hi_rise_a.size()), 32'(r0));
    check("post_rst_no_lo", 32'(lo_nib_a.size()), 32'(l0));
    check("post_rst_count", 32'(cnt_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
